lzs_stream_fifo: RTL and testbench

Synchronous first-word-fall-through FIFO, 64-bit data plus a per-word `last` tag, that sits between a stream producer (DMA read engine, compressor output) and the comp_unit data movers. Write side accepts active-low `putn` pushes and reports `full`/`almost_full`. Read side presents the head word combinationally with `empty`/`almost_empty` and pops on active-low `getn`. It is the source- and destination-queue element the copy/fill/compress engines stream through.

---
 rtl/lzs_stream_fifo.sv | 96 +++++++++
 tb/tb_lzs_stream_fifo.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lzs_stream_fifo.sv
// lzs_stream_fifo: first-word-fall-through FIFO, 64-bit data plus a last tag,
// used as the source/destination queue element of the copy/fill/compress engines.
// Full/empty come from the registered occupancy count, never from pointer equality.
module lzs_stream_fifo #(
    parameter int AW     = 4,
    parameter int AE_LVL = 1,
    parameter int AF_LVL = 1
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          flush,
    input  logic          putn,
    input  logic [63:0]   din,
    input  logic          din_last,
    output logic          full,
    output logic          almost_full,
    input  logic          getn,
    output logic [63:0]   dout,
    output logic          dout_last,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          ovf,
    output logic          udf
);
    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);
    localparam logic [AW:0] AF_C    = (AW+1)'(DEPTH - AF_LVL);

    logic [64:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          empty_q, aempty_q, full_q, afull_q, ovf_q, udf_q;
    logic          push_req, pop_req, push_ok, pop_ok, clr;
    logic [64:0]   head;

    assign clr      = wb_rst_i | flush;
    assign push_req = ~putn;
    assign pop_req  = ~getn;
    // Acceptance uses registered flags only, so a pop at full frees no slot this cycle
    assign push_ok  = push_req & ~full_q;
    assign pop_ok   = pop_req & ~empty_q;

    // Next occupancy: push-only +1, pop-only -1, otherwise unchanged
    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers, count, registered flags and sticky errors; reset/flush dominate
    always_ff @(posedge wb_clk_i) begin
        if (clr) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            aempty_q <= (count_d <= AE_C);
            full_q   <= (count_d == DEPTH_C);
            afull_q  <= (count_d >= AF_C);
            if (push_req && full_q)  ovf_q <= 1'b1;
            if (pop_req  && empty_q) udf_q <= 1'b1;
        end
    end

    // Storage write; contents are deliberately not cleared by reset/flush
    always_ff @(posedge wb_clk_i) begin
        if (push_ok && !clr) mem_q[wr_ptr_q] <= {din_last, din};
    end

    assign head      = mem_q[rd_ptr_q];
    assign dout      = empty_q ? 64'd0 : head[63:0];
    assign dout_last = empty_q ? 1'b0  : head[64];

    assign full         = full_q;
    assign almost_full  = afull_q;
    assign empty        = empty_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;
endmodule

// File: tb/tb_lzs_stream_fifo.sv
// Directed bench for lzs_stream_fifo: a default-threshold instance and an
// AE_LVL=4/AF_LVL=4 instance driven by the same stimulus.
module tb_lzs_stream_fifo;
    logic        clk = 1'b0;
    logic        rst, flush, putn, getn, din_last;
    logic [63:0] din;

    logic        a_full, a_af, a_empty, a_ae, a_dl, a_ovf, a_udf;
    logic [63:0] a_dout;
    logic [4:0]  a_count;
    logic        b_full, b_af, b_empty, b_ae, b_dl, b_ovf, b_udf;
    logic [63:0] b_dout;
    logic [4:0]  b_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lzs_stream_fifo #(.AW(4), .AE_LVL(1), .AF_LVL(1)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .flush(flush), .putn(putn), .din(din),
        .din_last(din_last), .full(a_full), .almost_full(a_af), .getn(getn),
        .dout(a_dout), .dout_last(a_dl), .empty(a_empty), .almost_empty(a_ae),
        .count(a_count), .ovf(a_ovf), .udf(a_udf));

    lzs_stream_fifo #(.AW(4), .AE_LVL(4), .AF_LVL(4)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .flush(flush), .putn(putn), .din(din),
        .din_last(din_last), .full(b_full), .almost_full(b_af), .getn(getn),
        .dout(b_dout), .dout_last(b_dl), .empty(b_empty), .almost_empty(b_ae),
        .count(b_count), .ovf(b_ovf), .udf(b_udf));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        putn = 1'b1; getn = 1'b1; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic do_flush();
        idle(); flush = 1'b1; tick(); flush = 1'b0;
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        putn = 1'b0; din = d; din_last = l; tick(); putn = 1'b1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_count"}, 64'(a_count), 64'd0);
        chk({tag, "_empty"}, 64'(a_empty), 64'd1);
        chk({tag, "_ae"},    64'(a_ae),    64'd1);
        chk({tag, "_full"},  64'(a_full),  64'd0);
        chk({tag, "_af"},    64'(a_af),    64'd0);
        chk({tag, "_dout"},  a_dout,       64'd0);
        chk({tag, "_dlast"}, 64'(a_dl),    64'd0);
        chk({tag, "_ovf"},   64'(a_ovf),   64'd0);
        chk({tag, "_udf"},   64'(a_udf),   64'd0);
    endtask

    initial begin
        idle(); din = '0; din_last = 1'b0;
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk_reset("rst");
        chk("rst_b_count", 64'(b_count), 64'd0);

        // Fill 16 words, last on word 15
        for (int i = 0; i < 16; i++) begin
            push(64'h1000 + 64'(i), i == 15);
            chk($sformatf("fill_count%0d", i), 64'(a_count), 64'(i + 1));
            chk($sformatf("fill_af%0d", i),    64'(a_af),    64'((i + 1) >= 15));
            chk($sformatf("fill_full%0d", i),  64'(a_full),  64'((i + 1) == 16));
            chk($sformatf("fill_ae%0d", i),    64'(a_ae),    64'((i + 1) <= 1));
            chk($sformatf("fill_head%0d", i),  a_dout,       64'h1000);
            chk($sformatf("fill_b_ae%0d", i),  64'(b_ae),    64'((i + 1) <= 4));
            chk($sformatf("fill_b_af%0d", i),  64'(b_af),    64'((i + 1) >= 12));
        end
        chk("fill_ovf", 64'(a_ovf), 64'd0);
        push(64'hDEAD, 1'b0);
        chk("ovf_set",   64'(a_ovf),   64'd1);
        chk("ovf_count", 64'(a_count), 64'd16);

        // Drain 16 words in order
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain_dout%0d", i),  a_dout,       64'h1000 + 64'(i));
            chk($sformatf("drain_last%0d", i),  64'(a_dl),    64'(i == 15));
            chk($sformatf("drain_count%0d", i), 64'(a_count), 64'(16 - i));
            chk($sformatf("drain_ae%0d", i),    64'(a_ae),    64'((16 - i) <= 1));
            getn = 1'b0; tick(); getn = 1'b1;
        end
        chk("drain_empty", 64'(a_empty), 64'd1);
        chk("drain_dout0", a_dout,       64'd0);
        chk("drain_last0", 64'(a_dl),    64'd0);
        chk("drain_udf0",  64'(a_udf),   64'd0);
        getn = 1'b0; tick(); getn = 1'b1;
        chk("udf_set",   64'(a_udf),   64'd1);
        chk("udf_count", 64'(a_count), 64'd0);

        // Streaming at steady count 3 across two pointer wraps
        do_flush();
        chk("flush_sticky", 64'({a_ovf, a_udf}), 64'd0);
        for (int k = 0; k < 3; k++) push(64'h2000 + 64'(k), 1'b0);
        for (int j = 0; j < 40; j++) begin
            chk($sformatf("strm_head%0d", j), a_dout, 64'h2000 + 64'(j));
            putn = 1'b0; getn = 1'b0; din = 64'h2000 + 64'(j + 3); din_last = 1'b0;
            tick();
            chk($sformatf("strm_count%0d", j), 64'(a_count), 64'd3);
        end
        idle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("strm_tail%0d", k), a_dout, 64'h2000 + 64'(40 + k));
            getn = 1'b0; tick(); getn = 1'b1;
        end
        chk("strm_empty", 64'(a_empty), 64'd1);

        // Push+pop at empty: push taken, pop rejected
        putn = 1'b0; getn = 1'b0; din = 64'h3333; din_last = 1'b1; tick(); idle();
        chk("pe_count", 64'(a_count), 64'd1);
        chk("pe_udf",   64'(a_udf),   64'd1);
        chk("pe_dout",  a_dout,       64'h3333);
        chk("pe_last",  64'(a_dl),    64'd1);

        // Push+pop at full: pop taken, push rejected
        for (int i = 0; i < 15; i++) push(64'h4000 + 64'(i), 1'b0);
        chk("pf_full", 64'(a_full), 64'd1);
        chk("pf_ovf0", 64'(a_ovf),  64'd0);
        putn = 1'b0; getn = 1'b0; din = 64'h5555; din_last = 1'b0; tick(); idle();
        chk("pf_count", 64'(a_count), 64'd15);
        chk("pf_ovf",   64'(a_ovf),   64'd1);
        chk("pf_head",  a_dout,       64'h4000);
        chk("pf_full1", 64'(a_full),  64'd0);

        // Flush with simultaneous push/pop at count 10
        do_flush();
        for (int i = 0; i < 10; i++) push(64'h6000 + 64'(i), 1'b0);
        chk("fl_count10", 64'(a_count), 64'd10);
        getn = 1'b0; tick(); getn = 1'b1;
        putn = 1'b0; tick(); putn = 1'b1;
        putn = 1'b0; getn = 1'b0; flush = 1'b1; din = 64'h7777; tick(); idle();
        chk_reset("flush");
        push(64'hABCD, 1'b0);
        chk("fl_head",  a_dout,       64'hABCD);
        chk("fl_count", 64'(a_count), 64'd1);

        // Reset mid-stream at count 7
        for (int i = 0; i < 6; i++) push(64'h8000 + 64'(i), 1'b0);
        chk("rm_count7", 64'(a_count), 64'd7);
        rst = 1'b1; putn = 1'b0; getn = 1'b0; tick(); idle();
        chk_reset("rstmid");
        chk("rstmid_b_count", 64'(b_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
